// File: rtl/univ_cnt_pkg.sv
// rtl/univ_cnt_pkg.sv - shared mode encodings for the universal modulus counter
// Purpose: holds the counter mode encoding used by univ_mod_counter and its bench.
// Ports:   none (package).
package univ_cnt_pkg;

    typedef enum logic [1:0] {
        MODE_BIN  = 2'b00,  // binary wrap at 2^N-1
        MODE_MOD  = 2'b01,  // wrap at mod_val
        MODE_SAT  = 2'b10,  // saturate at mod_val / 0
        MODE_HOLD = 2'b11   // freeze count and prescaler
    } cnt_mode_e;

endpackage

// File: rtl/cnt_prescaler.sv
// rtl/cnt_prescaler.sv - enable prescaler producing one step strobe per presc+1 enabled cycles
// Purpose: counts enabled cycles and strobes tick when the count reaches presc.
// Ports:   clk, reset_n (async active-low), clr (sync clear), en (count enable),
//          presc [PW-1:0] (terminal count), tick (combinational step strobe).
module cnt_prescaler #(
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr,
    input  logic          en,
    input  logic [PW-1:0] presc,
    output logic          tick
);

    logic [PW-1:0] count_q;
    logic [PW-1:0] count_d;

    // presc is compared live, so a change applies at the next comparison.
    // A clear on the same cycle suppresses the strobe.
    assign tick = en && !clr && (count_q == presc);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            if (count_q == presc) begin
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/univ_mod_counter.sv
// rtl/univ_mod_counter.sv - up/down counter with binary/modulus/saturate/hold modes and prescaler
// Purpose: N-bit counter stepped by a prescaled enable, with load, clear and terminal ticks.
// Ports:   clk, reset_n (async active-low), syn_clr, load, en, up, mode[1:0],
//          mod_val[N-1:0], presc[PW-1:0], d[N-1:0] -> q[N-1:0], max_tick, min_tick,
//          wrap_tick; with UNIV_CNT_STICKY_EN also flag_clr -> ovf_flag.
// Macro:   UNIV_CNT_STICKY_EN adds the sticky overflow flag.
module univ_mod_counter
    import univ_cnt_pkg::*;
#(
    parameter int N  = 8,
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          syn_clr,
    input  logic          load,
    input  logic          en,
    input  logic          up,
    input  logic [1:0]    mode,
    input  logic [N-1:0]  mod_val,
    input  logic [PW-1:0] presc,
    input  logic [N-1:0]  d,
    output logic [N-1:0]  q,
    output logic          max_tick,
    output logic          min_tick,
    output logic          wrap_tick
`ifdef UNIV_CNT_STICKY_EN
    ,
    input  logic          flag_clr,
    output logic          ovf_flag
`endif
);

    cnt_mode_e    mode_e;
    logic [N-1:0] term;
    logic         step;
    logic         hit_top;
    logic         hit_bot;
    logic         is_sat;
    logic         wrap_ev;

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;
    logic         wrap_q;
    logic         wrap_d;

    assign mode_e  = cnt_mode_e'(mode);
    assign term    = (mode_e == MODE_BIN) ? {N{1'b1}} : mod_val;
    assign is_sat  = (mode_e == MODE_SAT);
    // >= so that a loaded value above the terminal still wraps/saturates on the next up step.
    assign hit_top = (q_q >= term);
    assign hit_bot = (q_q == '0);

    // Hold mode freezes the prescaler by withholding its enable; load/clear still reset it.
    cnt_prescaler #(.PW(PW)) u_presc (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (syn_clr || load),
        .en      (en && (mode_e != MODE_HOLD)),
        .presc   (presc),
        .tick    (step)
    );

    always_comb begin
        q_d     = q_q;
        wrap_ev = 1'b0;
        if (syn_clr) begin
            q_d = '0;
        end else if (load) begin
            q_d = d;
        end else if (step) begin
            if (up) begin
                if (hit_top) begin
                    if (is_sat) begin
                        q_d = term;
                    end else begin
                        q_d     = '0;
                        wrap_ev = 1'b1;
                    end
                end else begin
                    q_d = q_q + 1'b1;
                end
            end else begin
                if (hit_bot) begin
                    if (is_sat) begin
                        q_d = '0;
                    end else begin
                        q_d     = term;
                        wrap_ev = 1'b1;
                    end
                end else begin
                    q_d = q_q - 1'b1;
                end
            end
        end
        // wrap_ev is already zero under clear/load, so the pulse self-clears.
        wrap_d = wrap_ev;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign q         = q_q;
    assign wrap_tick = wrap_q;
    assign max_tick  = (q_q == term);
    assign min_tick  = (q_q == '0);

`ifdef UNIV_CNT_STICKY_EN
    logic ovf_q;
    logic ovf_d;
    logic sat_block;

    // A saturate step that cannot move counts as an overflow event too.
    assign sat_block = step && !syn_clr && !load && is_sat && (up ? hit_top : hit_bot);

    always_comb begin
        ovf_d = ovf_q;
        if (syn_clr) begin
            ovf_d = 1'b0;
        end else if (wrap_ev || sat_block) begin
            ovf_d = 1'b1;
        end else if (flag_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_flag = ovf_q;
`endif

endmodule

// File: tb/tb_univ_mod_counter.sv
// tb/tb_univ_mod_counter.sv - scoreboard bench for univ_mod_counter against a reference model
module tb_univ_mod_counter;

    localparam int N  = 8;
    localparam int PW = 4;

    logic          clk;
    logic          reset_n;
    logic          syn_clr;
    logic          load;
    logic          en;
    logic          up;
    logic [1:0]    mode;
    logic [N-1:0]  mod_val;
    logic [PW-1:0] presc;
    logic [N-1:0]  d;
    logic [N-1:0]  q;
    logic          max_tick;
    logic          min_tick;
    logic          wrap_tick;
`ifdef UNIV_CNT_STICKY_EN
    logic          flag_clr;
    logic          ovf_flag;
`endif

    univ_mod_counter #(.N(N), .PW(PW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .syn_clr   (syn_clr),
        .load      (load),
        .en        (en),
        .up        (up),
        .mode      (mode),
        .mod_val   (mod_val),
        .presc     (presc),
        .d         (d),
        .q         (q),
        .max_tick  (max_tick),
        .min_tick  (min_tick),
        .wrap_tick (wrap_tick)
`ifdef UNIV_CNT_STICKY_EN
        ,
        .flag_clr  (flag_clr),
        .ovf_flag  (ovf_flag)
`endif
    );

    typedef struct {
        int q;
        bit mx;
        bit mn;
        bit wr;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   stim_done = 0;

    // Stimulus fields, copied onto the DUT pins at each negedge.
    bit t_rst, t_clr, t_load, t_en, t_up;
    int t_mode, t_mv, t_presc, t_d;

    // Reference model: plain integers, one update per clock edge.
    int m_q = 0, m_pc = 0;
    bit m_wr = 0;

    function automatic int term_of(int md, int mv);
        return (md == 0) ? (1 << N) - 1 : mv;
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int tv;
        tv = term_of(t_mode, t_mv);
        if (!t_rst) begin
            m_q = 0; m_pc = 0; m_wr = 0;
        end else if (t_clr) begin
            m_q = 0; m_pc = 0; m_wr = 0;
        end else if (t_load) begin
            m_q = t_d; m_pc = 0; m_wr = 0;
        end else begin
            m_wr = 0;
            if (t_mode != 3 && t_en) begin
                if (m_pc == t_presc) begin
                    m_pc = 0;
                    if (t_up) begin
                        if (m_q >= tv) begin
                            if (t_mode == 2) m_q = tv;
                            else begin m_q = 0; m_wr = 1; end
                        end else m_q = m_q + 1;
                    end else begin
                        if (m_q == 0) begin
                            if (t_mode == 2) m_q = 0;
                            else begin m_q = tv; m_wr = 1; end
                        end else m_q = m_q - 1;
                    end
                end else begin
                    m_pc = (m_pc + 1) % (1 << PW);
                end
            end
        end
    endtask

    // Drive one cycle of stimulus, advance the model, queue the expected response.
    task automatic apply();
        exp_t e;
        int tv;
        @(negedge clk);
        reset_n = t_rst;
        syn_clr = t_clr;
        load    = t_load;
        en      = t_en;
        up      = t_up;
        mode    = 2'(t_mode);
        mod_val = N'(t_mv);
        presc   = PW'(t_presc);
        d       = N'(t_d);
        model_edge();
        tv   = term_of(t_mode, t_mv);
        e.q  = m_q;
        e.mx = (m_q == tv);
        e.mn = (m_q == 0);
        e.wr = m_wr;
        sb.push_back(e);
        if (!t_rst) begin
            #1;
            cmp("async_rst_q", int'(q), 0);
            cmp("async_rst_wrap", int'(wrap_tick), 0);
            cmp("async_rst_min", int'(min_tick), 1);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_fields();
        t_rst = 1; t_clr = 0; t_load = 0; t_en = 0;
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: the DUT presents its state every cycle; compare against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp("q", int'(q), e.q);
                cmp("max_tick", int'(max_tick), int'(e.mx));
                cmp("min_tick", int'(min_tick), int'(e.mn));
                cmp("wrap_tick", int'(wrap_tick), int'(e.wr));
            end
        end
    end

    initial begin
        reset_n = 1'b0; syn_clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b0;
        mode = 2'b00; mod_val = '0; presc = '0; d = '0;
`ifdef UNIV_CNT_STICKY_EN
        flag_clr = 1'b0;
`endif
        t_mode = 0; t_mv = 0; t_presc = 0; t_d = 0; t_up = 1;
        idle_fields();
        t_rst = 0;
        apply();
        apply();
        idle_fields();
        apply();

        // Binary wrap: load FE, three steps -> FF, 00 with wrap, 01.
        t_mode = 0; t_presc = 0; t_up = 1;
        t_load = 1; t_d = 8'hFE; apply();
        t_load = 0; t_en = 1; apply();
        sync(); cmp("bin_ff", int'(q), 8'hFF); cmp("bin_ff_max", int'(max_tick), 1);
        apply();
        sync(); cmp("bin_wrap_q", int'(q), 0); cmp("bin_wrap_tick", int'(wrap_tick), 1);
        apply();
        sync(); cmp("bin_01", int'(q), 1); cmp("bin_01_nowrap", int'(wrap_tick), 0);

        // Modulus 9: down from 0, up from 9, load 12 then up.
        idle_fields(); t_mode = 1; t_mv = 9; t_clr = 1; apply();
        t_clr = 0; t_en = 1; t_up = 0; apply();
        sync(); cmp("mod_down_q", int'(q), 9); cmp("mod_down_wrap", int'(wrap_tick), 1);
        t_up = 1; apply();
        sync(); cmp("mod_up_q", int'(q), 0); cmp("mod_up_wrap", int'(wrap_tick), 1);
        t_en = 0; t_load = 1; t_d = 12; apply();
        t_load = 0; t_en = 1; apply();
        sync(); cmp("mod_over_q", int'(q), 0);

        // Saturate at 5.
        idle_fields(); t_mode = 2; t_mv = 5; t_load = 1; t_d = 5; apply();
        t_load = 0; t_en = 1; t_up = 1;
        repeat (3) apply();
        sync(); cmp("sat_q", int'(q), 5); cmp("sat_nowrap", int'(wrap_tick), 0);
`ifdef UNIV_CNT_STICKY_EN
        cmp("sat_ovf", int'(ovf_flag), 1);
`endif

        // Prescale by 4: twelve enabled cycles from 0 give 3, then a gap of 2 idle cycles.
        idle_fields(); t_mode = 0; t_presc = 3; t_clr = 1; apply();
        t_clr = 0; t_en = 1;
        repeat (12) apply();
        sync(); cmp("presc_q3", int'(q), 3);
        repeat (2) apply();
        t_en = 0; repeat (2) apply();
        t_en = 1; repeat (3) apply();

        // Clear beats load; then async reset in the middle of a prescale.
        idle_fields(); t_presc = 0; t_load = 1; t_d = 7; apply();
        t_load = 1; t_clr = 1; t_d = 3; apply();
        sync(); cmp("clr_over_load", int'(q), 0);
        idle_fields(); t_load = 1; t_d = 40; apply();
        t_load = 0; t_presc = 3; t_en = 1; repeat (2) apply();
        t_rst = 0; apply();
        idle_fields(); t_en = 1; repeat (5) apply();

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            t_rst  = ($urandom_range(0, 299) != 0);
            t_clr  = ($urandom_range(0, 59) == 0);
            t_load = ($urandom_range(0, 24) == 0);
            t_en   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) t_up = ~t_up;
            if ($urandom_range(0, 59) == 0) t_mode = $urandom_range(0, 3);
            if ($urandom_range(0, 49) == 0) t_mv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 11);
            if ($urandom_range(0, 39) == 0) t_presc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
            t_d = ($urandom_range(0, 1) == 1) ? $urandom_range(240, 255) : $urandom_range(0, 15);
            apply();
        end

        idle_fields();
        apply();
        repeat (3) @(posedge clk);
        #2;
        cmp("scoreboard_drained", sb.size(), 0);
        stim_done = 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
